// File: rtl/nts_tx_buffer.sv
// NTS transmit buffer: collects 64-bit packet words, then streams a committed
// frame to the MAC with a per-byte valid mask on the final word.
// Optional feature macro: NTS_TX_COUNTERS_EN adds frame/refusal counters.
module nts_tx_buffer #(
    parameter int unsigned ADDR_WIDTH = 7
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic                  i_clear,
    input  logic                  i_write_en,
    input  logic [63:0]           i_write_data,
    input  logic                  i_transmit,
    input  logic [ADDR_WIDTH+2:0] i_length_bytes,
    output logic                  o_busy,
    output logic                  o_overflow,
    output logic                  o_error,
    output logic                  o_mac_tx_start,
    input  logic                  i_mac_tx_ack,
    output logic [7:0]            o_mac_tx_data_valid,
    output logic [63:0]           o_mac_tx_data,
    output logic [31:0]           o_tx_packets,
    output logic [31:0]           o_tx_refused
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned PW    = ADDR_WIDTH + 1;  // pointer width, full != empty
    localparam int unsigned EW    = ADDR_WIDTH + 4;  // length plus rounding headroom

    typedef enum logic [1:0] {StIdle, StStart, StSend} state_e;

    state_e           state_q, state_d;
    logic [63:0]      mem [DEPTH];
    // Write pointer doubles as the word count.
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    n_words_q;
    logic [2:0]       rem_q;
    logic             overflow_q;
    logic             error_q;

    logic             idle;
    logic [EW-1:0]    len_ext;
    logic [PW-1:0]    n_words_in;
    logic             refuse;
    logic             tx_go;
    logic             tx_bad;
    logic             wr_req;
    logic             wr_ok;
    logic             wr_ovf;
    logic             last_word;
    logic [7:0]       valid_mask;
    logic [63:0]      data_mask;

    assign idle       = (state_q == StIdle);
    assign len_ext    = {1'b0, i_length_bytes} + EW'(7);
    assign n_words_in = len_ext[EW-1:3];
    assign refuse     = (i_length_bytes == '0) || (n_words_in > wr_ptr_q) || overflow_q;
    assign tx_go      = idle && i_transmit && !refuse;
    assign tx_bad     = idle && i_transmit && refuse;
    // Clear wins over a same-cycle write.
    assign wr_req     = idle && i_write_en && !i_clear;
    assign wr_ok      = wr_req && (wr_ptr_q != PW'(DEPTH));
    assign wr_ovf     = wr_req && (wr_ptr_q == PW'(DEPTH));
    assign last_word  = (rd_ptr_q == n_words_q - PW'(1));

    // Buffer RAM, no reset needed.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_write_data;
        end
    end

    // Write side state: pointer and sticky overflow.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (idle && i_clear) begin
            wr_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else if (wr_ok) begin
            wr_ptr_q   <= wr_ptr_q + PW'(1);
        end else if (wr_ovf) begin
            overflow_q <= 1'b1;
        end
    end

    // Frame parameters, read pointer and refusal pulse.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q   <= StIdle;
            rd_ptr_q  <= '0;
            n_words_q <= '0;
            rem_q     <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= tx_bad;
            if (tx_go) begin
                rd_ptr_q  <= '0;
                n_words_q <= n_words_in;
                rem_q     <= i_length_bytes[2:0];
            end else if (state_q == StSend) begin
                rd_ptr_q  <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Next-state logic; ack only matters in StStart.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (tx_go) state_d = StStart;
            StStart: if (i_mac_tx_ack) state_d = StSend;
            StSend:  if (last_word) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // MAC word output: partial final word keeps only its low r bytes.
    always_comb begin
        valid_mask          = 8'h00;
        data_mask           = '0;
        o_mac_tx_data_valid = 8'h00;
        o_mac_tx_data       = '0;
        if (state_q == StSend) begin
            if (last_word && (rem_q != 3'd0)) begin
                valid_mask = (8'd1 << rem_q) - 8'd1;
            end else begin
                valid_mask = 8'hFF;
            end
            for (int i = 0; i < 8; i++) begin
                data_mask[8*i +: 8] = {8{valid_mask[i]}};
            end
            o_mac_tx_data_valid = valid_mask;
            o_mac_tx_data       = mem[rd_ptr_q[ADDR_WIDTH-1:0]] & data_mask;
        end
    end

    assign o_busy         = !idle;
    assign o_overflow     = overflow_q;
    assign o_error        = error_q;
    assign o_mac_tx_start = (state_q == StStart);

`ifdef NTS_TX_COUNTERS_EN
    logic [31:0] tx_packets_q;
    logic [31:0] tx_refused_q;

    // Free-running wrap-around statistics, cleared only by reset.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            tx_packets_q <= '0;
            tx_refused_q <= '0;
        end else begin
            if ((state_q == StSend) && last_word) tx_packets_q <= tx_packets_q + 32'd1;
            if (tx_bad) tx_refused_q <= tx_refused_q + 32'd1;
        end
    end

    assign o_tx_packets = tx_packets_q;
    assign o_tx_refused = tx_refused_q;
`else
    assign o_tx_packets = '0;
    assign o_tx_refused = '0;
`endif

endmodule

// File: tb/tb_nts_tx_buffer.sv
// Self-checking bench for nts_tx_buffer (ADDR_WIDTH = 7).
module tb_nts_tx_buffer;

    localparam int AW    = 7;
    localparam int DEPTH = 2 ** AW;

    logic        clk = 1'b0;
    logic        i_areset = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_write_en = 1'b0;
    logic [63:0] i_write_data = '0;
    logic        i_transmit = 1'b0;
    logic [AW+2:0] i_length_bytes = '0;
    logic        i_mac_tx_ack = 1'b0;
    logic        o_busy, o_overflow, o_error, o_mac_tx_start;
    logic [7:0]  o_mac_tx_data_valid;
    logic [63:0] o_mac_tx_data;
    logic [31:0] o_tx_packets, o_tx_refused;

    nts_tx_buffer #(.ADDR_WIDTH(AW)) dut (
        .i_clk               (clk),
        .i_areset            (i_areset),
        .i_clear             (i_clear),
        .i_write_en          (i_write_en),
        .i_write_data        (i_write_data),
        .i_transmit          (i_transmit),
        .i_length_bytes      (i_length_bytes),
        .o_busy              (o_busy),
        .o_overflow          (o_overflow),
        .o_error             (o_error),
        .o_mac_tx_start      (o_mac_tx_start),
        .i_mac_tx_ack        (i_mac_tx_ack),
        .o_mac_tx_data_valid (o_mac_tx_data_valid),
        .o_mac_tx_data       (o_mac_tx_data),
        .o_tx_packets        (o_tx_packets),
        .o_tx_refused        (o_tx_refused)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  v;
        logic [63:0] d;
    } beat_t;

    int tests = 0;
    int fails = 0;

    // Model state
    logic [63:0] m_mem [DEPTH];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;
    bit          m_busy = 1'b0;
    int          m_packets = 0;
    int          m_refused = 0;
    beat_t       exp_q[$];

    // Per-frame observations from the compare process
    bit          in_frame = 1'b0;
    int          ff_cnt = 0;
    int          beat_cnt = 0;
    logic [7:0]  last_v = '0;
    logic [63:0] last_d = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare DUT beats against the model's expected frame every cycle.
    always @(negedge clk) begin
        if (!i_areset) begin
            if (o_mac_tx_data_valid != 8'h00) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got valid %h data %h expected no beat",
                             o_mac_tx_data_valid, o_mac_tx_data);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("beat_valid", {56'd0, o_mac_tx_data_valid}, {56'd0, b.v});
                    check("beat_data", o_mac_tx_data, b.d);
                    beat_cnt++;
                    if (o_mac_tx_data_valid == 8'hFF) ff_cnt++;
                    last_v = o_mac_tx_data_valid;
                    last_d = o_mac_tx_data;
                end
                in_frame = (exp_q.size() != 0);
            end else begin
                check("idle_data_zero", o_mac_tx_data, 64'd0);
                if (in_frame) begin
                    tests++;
                    fails++;
                    $display("FAIL frame_gap: got no beat expected %0d more beats", exp_q.size());
                    in_frame = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [63:0] d);
        i_write_en   = 1'b1;
        i_write_data = d;
        tick();
        i_write_en = 1'b0;
        if (!m_busy) begin
            if (m_cnt == DEPTH) m_ovf = 1'b1;
            else begin
                m_mem[m_cnt] = d;
                m_cnt++;
            end
        end
    endtask

    task automatic do_clear(input bit with_write);
        i_clear      = 1'b1;
        i_write_en   = with_write;
        i_write_data = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        i_clear    = 1'b0;
        i_write_en = 1'b0;
        m_cnt = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check_counters();
`ifdef NTS_TX_COUNTERS_EN
        check("tx_packets", {32'd0, o_tx_packets}, 64'(m_packets));
        check("tx_refused", {32'd0, o_tx_refused}, 64'(m_refused));
`else
        check("tx_packets_off", {32'd0, o_tx_packets}, 64'd0);
        check("tx_refused_off", {32'd0, o_tx_refused}, 64'd0);
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        in_frame  = 1'b0;
        m_cnt     = 0;
        m_ovf     = 1'b0;
        m_busy    = 1'b0;
        m_packets = 0;
        m_refused = 0;
    endtask

    // Issue a transmit; the model decides acceptance and the expected frame.
    task automatic try_transmit(input int len, input int ack_delay, input bit poke,
                                input int reset_at);
        int n;
        int r;
        bit refuse;
        n = (len + 7) / 8;
        r = len % 8;
        refuse = (len == 0) || (n > m_cnt) || m_ovf;
        ff_cnt = 0;
        beat_cnt = 0;
        i_transmit     = 1'b1;
        i_length_bytes = (AW + 3)'(len);
        tick();
        i_transmit = 1'b0;
        if (refuse) begin
            m_refused++;
            check("refuse_error", {63'd0, o_error}, 64'd1);
            check("refuse_busy", {63'd0, o_busy}, 64'd0);
            check("refuse_start", {63'd0, o_mac_tx_start}, 64'd0);
            tick();
            check("error_one_cycle", {63'd0, o_error}, 64'd0);
            check("refuse_no_start", {63'd0, o_mac_tx_start}, 64'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.v = 8'hFF;
            b.d = m_mem[i];
            if (i == n - 1 && r != 0) begin
                b.v = 8'((1 << r) - 1);
                b.d = m_mem[i] & ((64'd1 << (8 * r)) - 64'd1);
            end
            exp_q.push_back(b);
        end
        m_busy = 1'b1;
        check("accept_no_error", {63'd0, o_error}, 64'd0);
        check("accept_busy", {63'd0, o_busy}, 64'd1);
        for (int k = 0; k < ack_delay; k++) begin
            check("start_held", {63'd0, o_mac_tx_start}, 64'd1);
            tick();
        end
        check("start_before_ack", {63'd0, o_mac_tx_start}, 64'd1);
        i_mac_tx_ack = 1'b1;
        tick();
        i_mac_tx_ack = 1'b0;
        check("start_drops", {63'd0, o_mac_tx_start}, 64'd0);
        for (int k = 0; k < n; k++) begin
            check("busy_in_send", {63'd0, o_busy}, 64'd1);
            if (k == reset_at) begin
                #2 i_areset = 1'b1;
                #1;
                check("rst_busy", {63'd0, o_busy}, 64'd0);
                check("rst_start", {63'd0, o_mac_tx_start}, 64'd0);
                check("rst_valid", {56'd0, o_mac_tx_data_valid}, 64'd0);
                check("rst_data", o_mac_tx_data, 64'd0);
                check("rst_overflow", {63'd0, o_overflow}, 64'd0);
                check("rst_error", {63'd0, o_error}, 64'd0);
                model_reset();
                check_counters();
                tick();
                tick();
                #2 i_areset = 1'b0;
                return;
            end
            if (poke && k == 1) begin
                i_write_en   = 1'b1;
                i_write_data = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            tick();
            i_write_en = 1'b0;
        end
        check("busy_falls", {63'd0, o_busy}, 64'd0);
        check("frame_complete", 64'(exp_q.size()), 64'd0);
        m_busy = 1'b0;
        m_packets++;
    endtask

    initial begin
        // Reset state, asserted asynchronously at time 0
        #3;
        check("reset_busy", {63'd0, o_busy}, 64'd0);
        check("reset_start", {63'd0, o_mac_tx_start}, 64'd0);
        check("reset_valid", {56'd0, o_mac_tx_data_valid}, 64'd0);
        check("reset_data", o_mac_tx_data, 64'd0);
        check("reset_overflow", {63'd0, o_overflow}, 64'd0);
        #19 i_areset = 1'b0;
        check_counters();

        // Transmit needing more words than written, and zero length, both refused
        write_word(64'h0102_0304_0506_0708);
        write_word(64'h1112_1314_1516_1718);
        try_transmit(24, 0, 1'b0, -1);
        try_transmit(0, 0, 1'b0, -1);
        // Ack while idle is ignored
        i_mac_tx_ack = 1'b1;
        tick();
        i_mac_tx_ack = 1'b0;
        check("idle_ack_no_start", {63'd0, o_mac_tx_start}, 64'd0);
        check("idle_ack_busy", {63'd0, o_busy}, 64'd0);

        // 29 words, 230 bytes, ack after 3 cycles
        do_clear(1'b0);
        for (int i = 0; i < 29; i++) begin
            write_word(64'h8877_6655_4433_2211 + 64'(i) * 64'h0101_0101_0101_0101);
        end
        try_transmit(230, 3, 1'b0, -1);
        check("f230_ff_words", 64'(ff_cnt), 64'd28);
        check("f230_beats", 64'(beat_cnt), 64'd29);
        check("f230_last_valid", {56'd0, last_v}, 64'h3F);
        check("f230_last_hi_zero", {48'd0, last_d[63:48]}, 64'd0);
        check_counters();

        // Write attempted during SEND is ignored
        do_clear(1'b0);
        for (int i = 0; i < 4; i++) write_word(64'hA000_0000_0000_0000 | 64'(i));
        try_transmit(32, 1, 1'b1, -1);
        try_transmit(40, 0, 1'b0, -1);
        try_transmit(32, 0, 1'b0, -1);
        check("f32_last_word", last_d, 64'hA000_0000_0000_0003);

        // Reset in the middle of a frame, at word 5
        do_clear(1'b0);
        for (int i = 0; i < 10; i++) write_word(64'hC0C0_0000_0000_0000 + 64'(i));
        try_transmit(80, 2, 1'b0, 5);
        check("post_rst_busy", {63'd0, o_busy}, 64'd0);

        // Retransmit without rewriting
        write_word(64'h1122_3344_5566_7788);
        write_word(64'h99AA_BBCC_DDEE_FF00);
        try_transmit(16, 0, 1'b0, -1);
        try_transmit(16, 2, 1'b0, -1);
        check("retx_last_word", last_d, 64'h99AA_BBCC_DDEE_FF00);
`ifdef NTS_TX_COUNTERS_EN
        check("retx_packets_2", {32'd0, o_tx_packets}, 64'd2);
`endif
        check_counters();

        // Overflow: 129 writes into a 128-word buffer
        do_clear(1'b0);
        for (int i = 0; i < 129; i++) write_word(64'(i) << 8);
        check("overflow_set", {63'd0, o_overflow}, 64'd1);
        try_transmit(8, 0, 1'b0, -1);
        do_clear(1'b0);
        check("overflow_cleared", {63'd0, o_overflow}, 64'd0);
        // Clear wins over simultaneous write
        do_clear(1'b1);
        try_transmit(8, 0, 1'b0, -1);
        // Short frame after clear: 5 bytes -> one partial word
        write_word(64'hFFEE_DDCC_BBAA_9988);
        try_transmit(5, 1, 1'b0, -1);
        check("f5_valid", {56'd0, last_v}, 64'h1F);
        check("f5_data", last_d, 64'h0000_00CC_BBAA_9988);
        check_counters();

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nts_tx_buffer.md
NTS_TX_BUFFER -- requirements
Module: nts_tx_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 7, SHALL set buffer depth to 2**ADDR_WIDTH 64-bit words.
REQ-002 i_clk  in  1  clock; all logic SHALL be rising-edge.
REQ-003 i_areset  in  1  reset, asynchronous, active-high.
REQ-004 i_clear  in  1  SHALL zero the write pointer, the word count and o_overflow.
REQ-005 i_write_en  in  1  SHALL store i_write_data at the write pointer and increment the pointer.
REQ-006 i_write_data  in  64  packet word; byte 0 in [63:56] for full words.
REQ-007 i_transmit  in  1  pulse that commits the buffer for transmission.
REQ-008 i_length_bytes  in  ADDR_WIDTH+3  frame length in bytes, sampled with i_transmit.
REQ-009 o_busy  out  1  SHALL be high from accepted i_transmit until the last word is sent.
REQ-010 o_overflow  out  1  sticky write-overflow flag.
REQ-011 o_error  out  1  one-cycle pulse for a refused transmit.
REQ-012 o_mac_tx_start  out  1  frame request to the MAC.
REQ-013 i_mac_tx_ack  in  1  MAC grant, one-cycle pulse.
REQ-014 o_mac_tx_data_valid  out  8  byte-valid mask, same encoding as the MAC RX interface.
REQ-015 o_mac_tx_data  out  64  frame word.

Function
REQ-016 FSM states SHALL be IDLE, START, SEND; the reset state is IDLE.
REQ-017 In IDLE, writes SHALL be accepted.
- A write at word count 2**ADDR_WIDTH SHALL be dropped and SHALL set o_overflow.
REQ-018 i_transmit in IDLE SHALL be refused (o_error pulse, state unchanged) if any of the following holds:
- length is 0;
- ceil(length/8) exceeds the word count;
- o_overflow is set.
REQ-019 An accepted i_transmit SHALL enter START and assert o_busy on the next cycle.
REQ-020 In START, o_mac_tx_start SHALL be held high until i_mac_tx_ack is sampled high, then the FSM SHALL enter SEND.
REQ-021 The first word SHALL appear on the cycle after ack is sampled.
- N = ceil(length/8) words SHALL follow on consecutive cycles, with no gaps, in write order.
REQ-022 Non-final words SHALL carry valid 8'hFF.
- The final word with r = length mod 8 != 0 SHALL carry valid (1<<r)-1.
- Its r bytes SHALL sit in the low bits, with the unused high bits zero.
- r = 0 SHALL give 8'hFF.
REQ-023 Outside SEND, o_mac_tx_data_valid and o_mac_tx_data SHALL be 0.
REQ-024 After the final word, the FSM SHALL return to IDLE and o_busy SHALL fall on the following cycle.
- Buffer content and word count SHALL be preserved so that a retransmit is possible.
REQ-025 While o_busy, the following SHALL be ignored: i_write_en, i_clear, i_transmit, and i_mac_tx_ack outside START.
REQ-026 i_write_en and i_clear in the same cycle: the clear SHALL win and the write SHALL be dropped.
REQ-027 The write pointer SHALL be ADDR_WIDTH+1 bits so that the full condition is distinguishable from empty.

Reset
REQ-028 On i_areset, the block SHALL return to IDLE immediately, including mid-frame.
REQ-029 On i_areset, all outputs, the pointers, the word count and the counters SHALL be 0.
REQ-030 Buffer RAM contents are not required to reset.

Configuration
REQ-031 With macro NTS_TX_COUNTERS_EN defined, the following 32-bit outputs SHALL exist; both counters wrap at 2**32 and clear only on reset:
- o_tx_packets counts completed frames;
- o_tx_refused counts o_error pulses.
REQ-032 Without NTS_TX_COUNTERS_EN, o_tx_packets and o_tx_refused SHALL be driven constant 0 and no counter logic SHALL be synthesised.

Verification
REQ-033 Write 29 words, transmit 230 bytes, ack after 3 cycles. Required response:
- 28 words with valid FF;
- last word with valid 8'h3F and data[63:48]=0;
- busy falls 1 cycle after the last word.
REQ-034 Write 2 words, transmit 24 bytes -> o_error pulse, no o_mac_tx_start, state IDLE.
REQ-035 Write 129 words with ADDR_WIDTH=7. Required response:
- o_overflow=1;
- a subsequent transmit is refused;
- after i_clear, o_overflow=0.
REQ-036 Frame in progress, assert i_areset at word 5 -> all outputs 0 at once, IDLE, busy 0.
REQ-037 Transmit 16 bytes, then repeat the transmit without rewriting -> identical 2-word frames; with NTS_TX_COUNTERS_EN, o_tx_packets=2.
REQ-038 i_write_en pulsed during SEND -> frame data unchanged, word count unchanged.
